// File: rtl/ber_pkg.sv
// Shared types and helpers for the 16-QAM bit-error-rate meter.
package ber_pkg;

   localparam int SYM_W = 2;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      SEARCH  = 2'd1,
      MEASURE = 2'd2
   } ber_state_t;

   function automatic logic [1:0] popcount2(input logic [SYM_W-1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference-symbol delay line: shifts on enable, tap 0 is the live input.
module ber_delay_line #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 4,
   localparam int SEL_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] tap
);

   // Tap 0 is the live input, so only DEPTH-1 stages are stored.
   logic [WIDTH-1:0] line [DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH-1; k++) line[k] <= '0;
      end else if (shift) begin
         line[0] <= din;
         for (int k = 1; k < DEPTH-1; k++) line[k] <= line[k-1];
      end
   end

   always_comb begin
      tap = din;
      if (sel != '0) tap = line[sel - 1'b1];
   end

endmodule

// File: rtl/ber_meter.sv
// BER meter: finds tx-to-rx symbol latency, then counts bit errors per window.
// Optional macro BER_SER_COUNT_EN adds a per-window symbol-error counter.
module ber_meter
   import ber_pkg::*;
#(
   parameter int MAX_DELAY   = 63,
   parameter int ACQ_LEN     = 64,
   parameter int LOCK_THRESH = 2,
   parameter int WINDOW_LOG2 = 20,
   parameter int LOSS_THRESH = 2 ** (WINDOW_LOG2 - 2),
   localparam int DLY_W      = $clog2(MAX_DELAY + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sym_clk_ena,
   input  logic                   clear,
   input  logic [SYM_W-1:0]       ref_i,
   input  logic [SYM_W-1:0]       ref_q,
   input  logic [SYM_W-1:0]       rx_i,
   input  logic [SYM_W-1:0]       rx_q,
   output logic                   locked,
   output logic [DLY_W-1:0]       delay,
   output logic [WINDOW_LOG2+2:0] err_count,
   output logic                   result_valid,
   output logic [15:0]            window_count,
   output logic                   search_wrap,
   output logic [WINDOW_LOG2:0]   ser_count
);

   localparam int ACC_W  = WINDOW_LOG2 + 3;
   localparam int FILL_W = $clog2(MAX_DELAY + 1);
   localparam int ACQ_W  = $clog2(ACQ_LEN);
   localparam int MAX_FA = (FILL_W > ACQ_W) ? FILL_W : ACQ_W;
   localparam int CNT_W  = (MAX_FA > WINDOW_LOG2) ? MAX_FA : WINDOW_LOG2;

   ber_state_t           state, state_next;
   logic [CNT_W-1:0]     sym_cnt;
   logic [DLY_W-1:0]     cand;
   logic [DLY_W-1:0]     tap_sel;
   logic [ACC_W-1:0]     acc, acc_sum;
   logic [2*SYM_W-1:0]   ref_tap;
   logic [2:0]           sym_err;
   logic                 fill_done, acq_done, acq_pass, win_done, win_loss;

   assign tap_sel = (state == MEASURE) ? delay : cand;

   ber_delay_line #(
      .DEPTH (MAX_DELAY + 1),
      .WIDTH (2 * SYM_W)
   ) u_delay_line (
      .clk   (clk),
      .reset (reset),
      .shift (sym_clk_ena && !clear),
      .din   ({ref_i, ref_q}),
      .sel   (tap_sel),
      .tap   (ref_tap)
   );

   assign sym_err = {1'b0, popcount2(ref_tap[2*SYM_W-1:SYM_W] ^ rx_i)}
                  + {1'b0, popcount2(ref_tap[SYM_W-1:0] ^ rx_q)};
   assign acc_sum = acc + ACC_W'(sym_err);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      fill_done  = 1'b0;
      acq_done   = 1'b0;
      acq_pass   = 1'b0;
      win_done   = 1'b0;
      win_loss   = 1'b0;
      if (clear) begin
         state_next = FILL;
      end else if (sym_clk_ena) begin
         case (state)
            FILL: begin
               if (sym_cnt == CNT_W'(MAX_DELAY)) begin
                  fill_done  = 1'b1;
                  state_next = SEARCH;
               end
            end
            SEARCH: begin
               if (sym_cnt == CNT_W'(ACQ_LEN - 1)) begin
                  acq_done = 1'b1;
                  if (acc_sum <= ACC_W'(LOCK_THRESH)) begin
                     acq_pass   = 1'b1;
                     state_next = MEASURE;
                  end
               end
            end
            MEASURE: begin
               if (sym_cnt == CNT_W'(2 ** WINDOW_LOG2 - 1)) begin
                  win_done = 1'b1;
                  if (acc_sum > ACC_W'(LOSS_THRESH)) begin
                     win_loss   = 1'b1;
                     state_next = SEARCH;
                  end
               end
            end
            default: state_next = FILL;
         endcase
      end
   end

   // Every phase boundary restarts the symbol counter and the shared accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sym_cnt      <= '0;
         cand         <= '0;
         acc          <= '0;
         locked       <= 1'b0;
         delay        <= '0;
         err_count    <= '0;
         result_valid <= 1'b0;
         window_count <= '0;
         search_wrap  <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (clear) begin
            sym_cnt      <= '0;
            cand         <= '0;
            acc          <= '0;
            locked       <= 1'b0;
            window_count <= '0;
            search_wrap  <= 1'b0;
         end else if (sym_clk_ena) begin
            if (fill_done || acq_done || win_done) begin
               sym_cnt <= '0;
               acc     <= '0;
            end else begin
               sym_cnt <= sym_cnt + 1'b1;
               if (state != FILL) acc <= acc_sum;
            end
            if (acq_pass) begin
               delay        <= cand;
               locked       <= 1'b1;
               window_count <= '0;
            end else if (acq_done) begin
               if (cand == DLY_W'(MAX_DELAY)) begin
                  cand        <= '0;
                  search_wrap <= 1'b1;
               end else begin
                  cand <= cand + 1'b1;
               end
            end
            if (win_done) begin
               err_count    <= acc_sum;
               result_valid <= 1'b1;
               window_count <= window_count + 16'd1;
               if (win_loss) begin
                  locked <= 1'b0;
                  cand   <= '0;
               end
            end
         end
      end
   end

`ifdef BER_SER_COUNT_EN
   logic [WINDOW_LOG2:0] ser_acc, ser_sum;

   assign ser_sum = ser_acc + {{WINDOW_LOG2{1'b0}}, (sym_err != 3'd0)};

   // Symbol-error counter runs only while measuring and publishes with err_count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ser_acc   <= '0;
         ser_count <= '0;
      end else if (clear) begin
         ser_acc <= '0;
      end else if (sym_clk_ena && state == MEASURE) begin
         if (win_done) begin
            ser_count <= ser_sum;
            ser_acc   <= '0;
         end else begin
            ser_acc <= ser_sum;
         end
      end
   end
`else
   assign ser_count = '0;
`endif

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter with a 1024-symbol window.
module tb_ber_meter;

   localparam int WLOG = 10;
   localparam int WIN  = 2 ** WLOG;
   localparam int LOSS = 2 ** (WLOG - 2);
`ifdef BER_SER_COUNT_EN
   localparam bit SER_EN = 1'b1;
`else
   localparam bit SER_EN = 1'b0;
`endif

   logic            clk;
   logic            reset;
   logic            sym_clk_ena;
   logic            clear;
   logic [1:0]      ref_i, ref_q, rx_i, rx_q;
   logic            locked;
   logic [5:0]      delay;
   logic [WLOG+2:0] err_count;
   logic            result_valid;
   logic [15:0]     window_count;
   logic            search_wrap;
   logic [WLOG:0]   ser_count;

   int              nCompared;
   int              nMismatched;
   logic [3:0]      hist [16];
   logic [3:0]      curRef;
   int              chanDelay;
   bit              rxZero;

   typedef struct {
      logic [3:0] mask;
      int         nFlips;
      int         expErr;
      int         expSer;
   } win_vec_t;

   win_vec_t vecs [5];

   ber_meter #(
      .WINDOW_LOG2 (WLOG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sym_clk_ena  (sym_clk_ena),
      .clear        (clear),
      .ref_i        (ref_i),
      .ref_q        (ref_q),
      .rx_i         (rx_i),
      .rx_q         (rx_q),
      .locked       (locked),
      .delay        (delay),
      .err_count    (err_count),
      .result_valid (result_valid),
      .window_count (window_count),
      .search_wrap  (search_wrap),
      .ser_count    (ser_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One clock of stimulus; the bench history shifts exactly when the DUT line does.
   task automatic applyStimulus(input logic ena, input logic clr, input logic [3:0] flip);
      logic [3:0] r;
      logic [3:0] x;
      @(negedge clk);
      r = ena ? 4'($urandom_range(0, 15)) : curRef;
      curRef = r;
      x = rxZero ? 4'b0000 : (hist[chanDelay-1] ^ flip);
      sym_clk_ena = ena;
      clear = clr;
      {ref_i, ref_q} = r;
      {rx_i, rx_q} = x;
      @(posedge clk);
      if (ena && !clr) begin
         for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = r;
      end
      #1;
   endtask

   task automatic runLock(input string tag, input int nSym, input int expDelay);
      for (int i = 1; i <= nSym; i++) begin
         applyStimulus(1'b1, 1'b0, 4'b0000);
         if (i == nSym - 1) checkOutput({tag, "_not_yet"}, 32'(locked), 32'd0);
      end
      checkOutput({tag, "_locked"}, 32'(locked), 32'd1);
      checkOutput({tag, "_delay"}, 32'(delay), 32'(expDelay));
   endtask

   task automatic runWindow(input string tag, input logic [3:0] mask, input int nFlips,
                            input int expErr, input int expSer, input int expWc);
      logic [3:0] f;
      for (int s = 0; s < WIN; s++) begin
         f = 4'b0000;
         for (int j = 0; j < nFlips; j++) if (s == 100 + 200 * j) f = mask;
         applyStimulus(1'b1, 1'b0, f);
         if (s == WIN - 2) checkOutput({tag, "_rv_early"}, 32'(result_valid), 32'd0);
      end
      checkOutput({tag, "_rv"}, 32'(result_valid), 32'd1);
      checkOutput({tag, "_err"}, 32'(err_count), 32'(expErr));
      checkOutput({tag, "_ser"}, 32'(ser_count), SER_EN ? 32'(expSer) : 32'd0);
      checkOutput({tag, "_wc"}, 32'(window_count), 32'(expWc));
      checkOutput({tag, "_locked"}, 32'(locked), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'b0000);
      checkOutput({tag, "_rv_drop"}, 32'(result_valid), 32'd0);
      checkOutput({tag, "_err_hold"}, 32'(err_count), 32'(expErr));
   endtask

   initial begin
      vecs[0] = '{4'b0000, 1, 0, 0};
      vecs[1] = '{4'b0100, 1, 1, 1};
      vecs[2] = '{4'b1111, 1, 4, 1};
      vecs[3] = '{4'b1001, 3, 6, 3};
      vecs[4] = '{4'b1111, 2, 8, 2};

      nCompared = 0;
      nMismatched = 0;
      for (int k = 0; k < 16; k++) hist[k] = 4'b0000;
      curRef = 4'b0000;
      chanDelay = 5;
      rxZero = 1'b0;
      reset = 1'b0;
      sym_clk_ena = 1'b0;
      clear = 1'b0;
      {ref_i, ref_q, rx_i, rx_q} = '0;

      repeat (2) @(negedge clk);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_delay", 32'(delay), 32'd0);
      checkOutput("rst_err", 32'(err_count), 32'd0);
      checkOutput("rst_rv", 32'(result_valid), 32'd0);
      checkOutput("rst_wc", 32'(window_count), 32'd0);
      checkOutput("rst_wrap", 32'(search_wrap), 32'd0);
      checkOutput("rst_ser", 32'(ser_count), 32'd0);
      reset = 1'b1;

      // 64 fill symbols plus candidates 0..5 at 64 symbols each.
      runLock("acq5", 64 + 6 * 64, 5);
      checkOutput("acq5_wrap", 32'(search_wrap), 32'd0);

      for (int v = 0; v < 5; v++)
         runWindow($sformatf("win%0d", v), vecs[v].mask, vecs[v].nFlips,
                   vecs[v].expErr, vecs[v].expSer, v + 1);

      // Channel latency jumps to 9: the window is mostly errors, so lock drops.
      chanDelay = 9;
      for (int s = 0; s < WIN; s++) applyStimulus(1'b1, 1'b0, 4'b0000);
      checkOutput("loss_rv", 32'(result_valid), 32'd1);
      checkOutput("loss_locked", 32'(locked), 32'd0);
      checkOutput("loss_err_above_thresh", 32'(err_count > (WLOG+3)'(LOSS)), 32'd1);
      checkOutput("loss_wc", 32'(window_count), 32'd6);
      runLock("relock9", 10 * 64, 9);
      checkOutput("relock9_wc", 32'(window_count), 32'd0);

      // Clear mid-window keeps the last published err_count and restarts from FILL.
      runWindow("pre_clr", 4'b1111, 2, 8, 2, 1);
      for (int s = 0; s < 500; s++) applyStimulus(1'b1, 1'b0, 4'b0000);
      applyStimulus(1'b1, 1'b1, 4'b0000);
      checkOutput("clr_locked", 32'(locked), 32'd0);
      checkOutput("clr_wc", 32'(window_count), 32'd0);
      checkOutput("clr_err_hold", 32'(err_count), 32'd8);
      checkOutput("clr_rv", 32'(result_valid), 32'd0);
      checkOutput("clr_ser_hold", 32'(ser_count), SER_EN ? 32'd2 : 32'd0);
      runLock("clr_relock", 64 + 10 * 64, 9);

      // Constant rx never locks; idle cycles in between must not advance the search.
      rxZero = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'b0000);
      for (int i = 1; i <= 64 + 64 * 64; i++) begin
         if (i % 7 == 0) applyStimulus(1'b0, 1'b0, 4'b0000);
         applyStimulus(1'b1, 1'b0, 4'b0000);
         if (i == 64 + 64 * 64 - 1) checkOutput("wrap_early", 32'(search_wrap), 32'd0);
      end
      checkOutput("wrap_set", 32'(search_wrap), 32'd1);
      checkOutput("wrap_locked", 32'(locked), 32'd0);

      // Async reset mid-measurement clears outputs without a clock edge.
      rxZero = 1'b0;
      chanDelay = 5;
      applyStimulus(1'b1, 1'b1, 4'b0000);
      checkOutput("pre_rst_wrap_cleared", 32'(search_wrap), 32'd0);
      runLock("pre_rst", 64 + 6 * 64, 5);
      for (int s = 0; s < 100; s++) applyStimulus(1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("arst_locked", 32'(locked), 32'd0);
      checkOutput("arst_delay", 32'(delay), 32'd0);
      checkOutput("arst_err", 32'(err_count), 32'd0);
      checkOutput("arst_ser", 32'(ser_count), 32'd0);
      #5 reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
